inst_fetch: RTL and testbench

Instruction fetch stage, directly upstream of the instruction decoder. Holds the program counter and issues word requests to instruction memory over a request/grant/rvalid handshake. Buffers returned words with their PCs in a small queue and presents them to decode over a valid/ready handshake. On a redirect (branch, jump or exception target) it flushes the queue and discards the responses still in flight.

---
 rtl/inst_fetch_pkg.sv | 11 +
 rtl/inst_fetch_queue.sv | 52 +++++
 rtl/inst_fetch.sv | 106 ++++++++++
 tb/tb_inst_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch stage.
package inst_fetch_pkg;
  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {RUN, DRAIN} fetch_state_t;
endpackage

// File: rtl/inst_fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush empties it and wins over push/pop.
module fetch_queue
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic                         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, credit-limited imem requests, response queue to decode, redirect flush.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);
  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d;
  logic [CW:0]   occ;
  logic          fire, pop, keep;

  fetch_entry_t  dec_head, infl_head;
  logic [CW-1:0] dec_count, infl_count;
  logic          dec_empty, dec_full, infl_empty, infl_full;
  logic          unused;

  // The slot being popped this cycle counts as free, so a DEPTH=2 stage
  // can stream one word per cycle; the queue still never overflows.
  assign pop      = inst_valid & inst_ready;
  assign occ      = {1'b0, dec_count} + {1'b0, out_q} - (CW+1)'(pop);
  assign imem_req = rst_n & ~redirect & (occ < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign fire     = imem_req & imem_gnt;
  assign keep     = imem_rvalid & (drop_q == '0) & ~redirect;

  assign inst_valid = ~dec_empty;
  assign inst       = inst_valid ? dec_head.inst : '0;
  assign inst_pc    = inst_valid ? dec_head.pc   : '0;

  always_comb begin
    out_d      = out_q + CW'(fire) - CW'(imem_rvalid);
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    if (fire) fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
    if (imem_rvalid && drop_q != '0) drop_d = drop_q - 1'b1;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = out_d;
    end
    state_d = state_q;
    case (state_q)
      RUN:     if (redirect && drop_d != '0) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  // In-flight PCs of live requests only; dropped ones are never pushed/popped.
  fetch_queue #(.DEPTH(DEPTH)) u_infl (
    .clk, .rst_n,
    .push_i      (fire & ~redirect),
    .push_data_i ('{pc: fetch_pc_q, inst: 32'h0}),
    .pop_i       (keep),
    .flush_i     (redirect),
    .head_o      (infl_head),
    .count_o     (infl_count),
    .empty_o     (infl_empty),
    .full_o      (infl_full)
  );

  fetch_queue #(.DEPTH(DEPTH)) u_dec (
    .clk, .rst_n,
    .push_i      (keep),
    .push_data_i ('{pc: infl_head.pc, inst: imem_rdata}),
    .pop_i       (pop),
    .flush_i     (redirect),
    .head_o      (dec_head),
    .count_o     (dec_count),
    .empty_o     (dec_empty),
    .full_o      (dec_full)
  );

  assign unused = ^{infl_head.inst, infl_count, infl_empty, infl_full, dec_full, redirect_pc[1:0]};
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch with a 1-cycle in-order memory model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid, redirect, inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;

  int          total = 0, bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] pipe[$], fired_q[$];
  bit          gnt_en, rsp_hold, hold_pend, want_first;
  logic [31:0] hold_addr, want_pc, s_addr, s_pc;
  logic        s_req, s_valid;
  int          s_pipe;
  logic [31:0] a_seq[8], p_seq[8];
  logic        r_seq[8], v_seq[8];

  inst_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic [31:0] fq(input int i);
    return (i < fired_q.size()) ? fired_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Called at a negedge; samples 1ns before the posedge, then advances the memory model.
  task automatic step();
    logic        f;
    logic [31:0] a;
    logic [63:0] e;
    #4;
    f = imem_req & imem_gnt;
    a = imem_addr;
    chk("addr_lsb", {30'b0, a[1:0]}, 32'h0);
    if (hold_pend && !redirect) begin
      chk("hold_req", 32'(imem_req), 32'h1);
      chk("hold_addr", a, hold_addr);
    end
    if (redirect) chk("req_redir", 32'(imem_req), 32'h0);
    if (inst_valid && inst_ready) begin
      if (exp_q.size() == 0) chk("unexp_pop", 32'(inst_valid), 32'h0);
      else begin
        e = exp_q.pop_front();
        chk("inst_pc", inst_pc, e[63:32]);
        chk("inst", inst, e[31:0]);
        if (want_first) begin
          chk("first_pc", inst_pc, want_pc);
          want_first = 1'b0;
        end
      end
    end
    if (redirect) exp_q.delete();
    if (f && !redirect) begin
      exp_q.push_back({a, mdat(a)});
      fired_q.push_back(a);
    end
    s_req = imem_req; s_addr = a; s_valid = inst_valid; s_pc = inst_pc; s_pipe = pipe.size();
    hold_pend = imem_req & ~imem_gnt & ~redirect;
    hold_addr = a;
    @(negedge clk);
    redirect = 1'b0;
    if (f) pipe.push_back(a);
    if (!rsp_hold && pipe.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mdat(pipe.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    imem_gnt = gnt_en;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    redirect = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pipe.delete(); exp_q.delete();
    hold_pend = 1'b0; rsp_hold = 1'b0; gnt_en = 1'b1; imem_gnt = 1'b1; want_first = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_vld", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    inst_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    reset_dut();

    // streaming: back-to-back requests and back-to-back outputs
    for (int i = 0; i < 8; i++) begin
      step();
      a_seq[i] = s_addr; r_seq[i] = s_req; p_seq[i] = s_pc; v_seq[i] = s_valid;
    end
    for (int i = 0; i < 3; i++) begin
      chk("seq_req", 32'(r_seq[i]), 32'h1);
      chk("seq_addr", a_seq[i], 32'(i * 4));
      chk("seq_vld", 32'(v_seq[i+2]), 32'h1);
      chk("seq_pc", p_seq[i+2], 32'(i * 4));
    end
    chk("seq_lat", 32'(v_seq[1]), 32'h0);

    // decoder stall: credit exhausted, nothing lost on release
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) begin
        chk("bp_req", 32'(s_req), 32'h0);
        chk("bp_vld", 32'(s_valid), 32'h1);
      end
    end
    inst_ready = 1'b1;
    repeat (10) step();

    // grant withheld 3 cycles at 0x8
    reset_dut();
    step();
    gnt_en = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) gnt_en = 1'b1;
      step();
      chk("gh_req", 32'(s_req), 32'h1);
      chk("gh_addr", s_addr, 32'h8);
    end
    fired_q.delete();
    step(); step();
    chk("gh_f0", fq(0), 32'h8);
    chk("gh_f1", fq(1), 32'hC);

    // redirect with two responses outstanding
    repeat (4) step();
    rsp_hold = 1'b1;
    repeat (4) step();
    chk("cr_req", 32'(s_req), 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0000_1003;
    step();
    chk("rd_drop", 32'(dut.drop_q), 32'h2);
    chk("rd_state", 32'(dut.state_q), 32'(DRAIN));
    rsp_hold = 1'b0; want_first = 1'b1; want_pc = 32'h0000_1000;
    step();
    chk("rd_addr", s_addr, 32'h0000_1000);
    chk("rd_vld", 32'(s_valid), 32'h0);
    repeat (10) step();
    chk("rd_seen", 32'(want_first), 32'h0);

    // redirect in the same cycle as a grant and an rvalid
    rsp_hold = 1'b1;
    step();
    rsp_hold = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h0000_2000;
    step();
    chk("rs_drop", 32'(dut.drop_q), 32'(s_pipe));
    chk("rs_state", 32'(dut.state_q), (s_pipe != 0) ? 32'(DRAIN) : 32'(RUN));
    want_first = 1'b1; want_pc = 32'h0000_2000;
    repeat (10) step();
    chk("rs_seen", 32'(want_first), 32'h0);

    // fetch_pc wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    fired_q.delete();
    want_first = 1'b1; want_pc = 32'hFFFF_FFF8;
    repeat (10) step();
    chk("wr_f0", fq(0), 32'hFFFF_FFF8);
    chk("wr_f1", fq(1), 32'hFFFF_FFFC);
    chk("wr_f2", fq(2), 32'h0000_0000);
    chk("wr_seen", 32'(want_first), 32'h0);

    // asynchronous reset while draining
    rsp_hold = 1'b1;
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    step();
    chk("dr_state", 32'(dut.state_q), 32'(DRAIN));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(imem_req), 32'h0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_vld", 32'(inst_valid), 32'h0);
    chk("ar_inst", inst, 32'h0);
    chk("ar_pc", inst_pc, 32'h0);
    chk("ar_drop", 32'(dut.drop_q), 32'h0);
    chk("ar_state", 32'(dut.state_q), 32'(RUN));
    reset_dut();
    step();
    chk("ar_req1", 32'(s_req), 32'h1);
    chk("ar_addr1", s_addr, 32'h0);
    repeat (10) step();

    // stop granting and drain everything that was issued
    gnt_en = 1'b0;
    repeat (6) step();
    chk("end_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
